// File: rtl/custom_instr_pkg.sv
// Shared definitions for the count-bits custom-instruction issue path.
// Contents:
//   cntb_seq_state_e          sequencer FSM states
//   CNTB_SEQ_TIMEOUT_DEFAULT  default WAIT budget in cycles
//   CNTB_IDX_W                width of a legal start-bit index
//   cntb_idx_legal()          1 when an rs1 value fits in CNTB_IDX_W bits
package custom_instr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    FLUSH = 3'd4
  } cntb_seq_state_e;

  localparam int unsigned CNTB_SEQ_TIMEOUT_DEFAULT = 16;
  localparam int unsigned CNTB_IDX_W               = 5;

  // A start index is legal only if every bit above the index field is clear.
  function automatic logic cntb_idx_legal(input logic [31:0] rs1);
    return rs1[31:CNTB_IDX_W] == '0;
  endfunction

endpackage

// File: rtl/cntb_seq_tmo.sv
// Timeout counter for the count-bits sequencer.
// The count is cleared when an instruction is accepted, advances once per
// enabled cycle, and signals expiry during the enabled cycle in which it
// holds TIMEOUT_CYCLES-1 (the last cycle of the budget).
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          reload the count to zero
//   en_i           count this cycle (sequencer is in WAIT)
//   expire_o       budget exhausted in this cycle
module cntb_seq_tmo
  import custom_instr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = CNTB_SEQ_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/cntb_seq.sv
// Issue/writeback sequencer in front of the count-bits custom-instruction unit.
// Accepts (rs0, rs1, tag) from EX, pulses the unit's start, accumulates the
// unit's per-cycle partial counts until done, and returns the count with its
// tag to writeback. An out-of-range bit index or a WAIT timeout returns err=1.
// After a timeout the sequencer parks in FLUSH until the unit's late done so
// that a new instruction never meets a still-busy unit.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   issue_valid_i/issue_ready_o         EX handshake
//   issue_rs0_i/issue_rs1_i/issue_tag_i operand word, start index, dest tag
//   unit_start_o                        one-cycle start pulse
//   unit_rs0_o/unit_rs1_o               registered operands (rs1 zero-extended index)
//   unit_acc_o                          count accumulated before this cycle
//   unit_partial_i/unit_done_i          unit's per-cycle count and done pulse
//   wb_valid_o/wb_ready_i               writeback handshake
//   wb_result_o/wb_tag_o/wb_err_o       result, tag, error flag
module cntb_seq
  import custom_instr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = CNTB_SEQ_TIMEOUT_DEFAULT,
  parameter int unsigned TAG_W          = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [31:0]      issue_rs0_i,
  input  logic [31:0]      issue_rs1_i,
  input  logic [TAG_W-1:0] issue_tag_i,
  output logic             unit_start_o,
  output logic [31:0]      unit_rs0_o,
  output logic [31:0]      unit_rs1_o,
  output logic [31:0]      unit_acc_o,
  input  logic [31:0]      unit_partial_i,
  input  logic             unit_done_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      wb_result_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             wb_err_o
);

  cntb_seq_state_e       state_q, state_d;
  logic [31:0]           rs0_q;
  logic [CNTB_IDX_W-1:0] idx_q;
  logic [TAG_W-1:0]      tag_q;
  logic [31:0]           acc_q;
  logic                  err_q;
  logic                  pending_flush_q;

  logic                  accept;
  logic                  tmo_expire;
  logic [31:0]           acc_sum;

  assign issue_ready_o = (state_q == IDLE);
  assign accept        = issue_valid_i && issue_ready_o;
  assign acc_sum       = acc_q + unit_partial_i;  // wraps modulo 2^32

  cntb_seq_tmo #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (accept),
    .en_i     (state_q == WAIT),
    .expire_o (tmo_expire)
  );

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (issue_valid_i) state_d = cntb_idx_legal(issue_rs1_i) ? START : RESP;
      START: state_d = WAIT;
      WAIT:  if (unit_done_i || tmo_expire) state_d = RESP;
      // A done seen in the handshake cycle itself already drained the unit.
      RESP:  if (wb_ready_i) state_d = (pending_flush_q && !unit_done_i) ? FLUSH : IDLE;
      FLUSH: if (unit_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand, tag and accumulator registers are reset as well because
  // they drive ports whose values are defined while reset is asserted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      rs0_q           <= '0;
      idx_q           <= '0;
      tag_q           <= '0;
      acc_q           <= '0;
      err_q           <= 1'b0;
      pending_flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (issue_valid_i) begin
            rs0_q           <= issue_rs0_i;
            idx_q           <= issue_rs1_i[CNTB_IDX_W-1:0];
            tag_q           <= issue_tag_i;
            acc_q           <= '0;
            err_q           <= !cntb_idx_legal(issue_rs1_i);
            pending_flush_q <= 1'b0;
          end
        end
        WAIT: begin
          acc_q <= acc_sum;
          // Done wins over a simultaneous expiry.
          if (!unit_done_i && tmo_expire) begin
            err_q           <= 1'b1;
            pending_flush_q <= 1'b1;
          end
        end
        RESP: begin
          if (unit_done_i) pending_flush_q <= 1'b0;
        end
        FLUSH: begin
          if (unit_done_i) pending_flush_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign unit_start_o = (state_q == START);
  assign unit_rs0_o   = rs0_q;
  assign unit_rs1_o   = {{(32 - CNTB_IDX_W){1'b0}}, idx_q};
  assign unit_acc_o   = acc_q;
  assign wb_valid_o   = (state_q == RESP);
  assign wb_result_o  = acc_q;
  assign wb_tag_o     = tag_q;
  assign wb_err_o     = err_q;

endmodule

// File: doc/cntb_seq.md
Name: cntb_seq

Overview:
- Issue/writeback sequencer directly upstream of the count-bits custom-instruction unit.
- Accepts a decoded custom instruction (rs0, rs1, destination tag) from the EX stage via valid/ready.
- Registers the operands, pulses the unit's start, and accumulates per-cycle partial counts until the unit reports done.
- Returns the result with its tag to writeback via valid/ready, with an error flag for an illegal bit index or a timeout.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT before the operation is aborted with an error.
- TAG_W, 5: width of the destination-register tag passed through unchanged.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  instruction offered
- issue_ready_o  out  1  sequencer can accept
- issue_rs0_i  in  32  operand word
- issue_rs1_i  in  32  start bit index
- issue_tag_i  in  TAG_W  destination tag
- unit_start_o  out  1  one-cycle start pulse to the unit
- unit_rs0_o  out  32  registered rs0, held stable for the whole operation
- unit_rs1_o  out  32  registered rs1, zero-extended 5-bit index
- unit_acc_o  out  32  count accumulated before the current cycle (unit feedback)
- unit_partial_i  in  32  unit's per-cycle partial count, 0 when idle
- unit_done_i  in  1  unit done pulse
- wb_valid_o  out  1  result available
- wb_ready_i  in  1  writeback accepts
- wb_result_o  out  32  accumulated count
- wb_tag_o  out  TAG_W  tag of the result
- wb_err_o  out  1  1 = illegal index or timeout

Behaviour:
- Reset values:
  - state IDLE; all registers 0.
  - issue_ready_o=1, unit_start_o=0, wb_valid_o=0, wb_err_o=0.
  - wb_result_o=0, unit_* outputs 0.
- States: IDLE, START, WAIT, RESP, FLUSH.
- IDLE:
  - issue_ready_o=1 only in this state.
  - On issue_valid_i: capture rs0, rs1, tag; clear acc and the timeout counter.
  - If issue_rs1_i[31:5]!=0: go to RESP with err=1 and result=0; the unit is never started.
  - Otherwise go to START.
- START:
  - unit_start_o=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Every cycle: acc <= acc + unit_partial_i; timeout counter increments.
  - On unit_done_i: go to RESP with result = acc + unit_partial_i, err=0.
  - If done and timeout expiry occur in the same cycle, done wins.
  - When the counter reaches TIMEOUT_CYCLES-1 without done: go to RESP with err=1, result = acc so far, and set pending_flush=1.
- RESP:
  - wb_valid_o=1; result, tag and err held stable until wb_ready_i.
  - On handshake: go to FLUSH if pending_flush, else IDLE.
  - unit_done_i arriving during RESP clears pending_flush.
- FLUSH:
  - Ignores unit_partial_i and waits for unit_done_i, with no timeout; then go to IDLE.
  - Prevents issuing while the unit is still busy.
- Arithmetic: acc is 32-bit, wraps modulo 2^32; no saturation.
- Latency:
  - Issue accept at cycle 0, START at 1, first WAIT at 2.
  - For a single-pass unit operation, done at cycle 3 and wb_valid_o at cycle 4.
  - Back-to-back operation: accept in the cycle after the writeback handshake.
- Operand outputs hold their captured values from START through WAIT/FLUSH; they do not change in RESP.
- Reset mid-operation clears everything to reset values; no result is produced.

Decomposition:
- custom_instr_pkg:
  - cntb_seq_state_e enum (IDLE, START, WAIT, RESP, FLUSH).
  - CNTB_SEQ_TIMEOUT_DEFAULT=16.
  - CNTB_IDX_W=5.
- One sub-module, cntb_seq_tmo: a loadable timeout counter with clear, enable and expire outputs, parameterised by TIMEOUT_CYCLES.
- The FSM, accumulator and handshake logic live in cntb_seq.

Test Plan (the bench drives a behavioural unit model):
- Single pass: issue rs0=0xF0000000, rs1=31, tag=3; model returns partial 4 at WAIT cycle 1, then done → wb_valid at cycle 4, result=4, tag=3, err=0, exactly one unit_start pulse.
- Multi-pass: model returns partials 8, 8, 3 on successive WAIT cycles, then done → result=19; unit_acc_o observed as 0, 8, 16.
- Illegal index: rs1=32 → unit_start_o never asserted; wb_valid at cycle 1 after accept, result=0, err=1.
- Timeout: model never signals done → after 16 WAIT cycles wb_valid with err=1; issue_ready_o stays 0 through FLUSH until the model's late done pulse, then returns to 1.
- Writeback backpressure: wb_ready_i=0 for 5 cycles → result/tag/err stable, issue_ready_o=0; accept occurs in the cycle after the handshake.
- Async reset asserted during WAIT with acc=8 → all outputs at reset values immediately; the next issue yields the correct fresh result.
